// File: rtl/dco_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dco_pkg
//  Description : Shared defaults, width helper and tuning-word layout for the
//                DCO tuning-word decoder and its thermometer sub-block.
//  Revision    : 1.0 - initial release
// ============================================================================
package dco_pkg;

  localparam int INT_W_DEFAULT  = 6;
  localparam int FRAC_W_DEFAULT = 4;

  // Number of unit cells driven by an int_w-bit integer code.
  function automatic int therm_width(input int int_w);
    return (1 << int_w) - 1;
  endfunction

  // Tuning word as delivered by the loop filter: integer part in the MSBs.
  typedef struct packed {
    logic [INT_W_DEFAULT-1:0]  int_part;
    logic [FRAC_W_DEFAULT-1:0] frac_part;
  } tune_word_t;

endpackage
`default_nettype wire

// File: rtl/dco_bin2therm.sv
`default_nettype none
// ============================================================================
//  Module      : dco_bin2therm
//  Description : Combinational binary-to-thermometer converter. Bit k of the
//                output is set when the code exceeds k, so the result is
//                bubble-free by construction.
//  Revision    : 1.0 - initial release
// ============================================================================
module dco_bin2therm
  import dco_pkg::*;
#(
  parameter int INT_W = INT_W_DEFAULT
) (
  input  logic [INT_W-1:0]              code_i,
  output logic [therm_width(INT_W)-1:0] therm_o
);

  // One comparator per unit cell.
  for (genvar k = 0; k < therm_width(INT_W); k++) begin : g_bit
    assign therm_o[k] = (code_i > INT_W'(k));
  end

endmodule
`default_nettype wire

// File: rtl/dco_tw_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : dco_tw_decoder
//  Description : Registers the DCO tuning word, dithers the fractional part
//                onto the integer code with a first-order sigma-delta
//                accumulator, clips to the bank size and drives a registered
//                thermometer code to the varactor array.
//  Revision    : 1.0 - initial release
// ============================================================================
module dco_tw_decoder
  import dco_pkg::*;
#(
  parameter int INT_W  = INT_W_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clr,
  input  logic                          tune_valid,
  input  logic [INT_W+FRAC_W-1:0]       tune_i,
  output logic [therm_width(INT_W)-1:0] therm_o,
  output logic [INT_W-1:0]              code_o,
  output logic                          sat_o
);

  localparam int               T       = therm_width(INT_W);
  localparam logic [INT_W:0]   c_t_max = (INT_W+1)'(T);

  logic [INT_W-1:0]  int_q,   int_d;
  logic [FRAC_W-1:0] frac_q,  frac_d;
  logic [FRAC_W-1:0] acc_q,   acc_d;
  logic [INT_W-1:0]  code_q,  code_d;
  logic [T-1:0]      therm_q, therm_d;
  logic              sat_q,   sat_d;

  logic [FRAC_W:0]   w_sum;
  logic              w_carry;
  logic [INT_W:0]    w_raw;
  logic              w_sat;
  logic [INT_W-1:0]  w_code;
  logic [T-1:0]      w_therm;

  // Stage 1: capture a qualified tuning word, otherwise keep the last one.
  always_comb begin
    int_d  = int_q;
    frac_d = frac_q;
    if (en && tune_valid) begin
      {int_d, frac_d} = tune_i;
    end
  end

  // Stage 2 datapath: sigma-delta carry, integer add and clip to the bank.
  // clr kills the carry of its own cycle so the restart is deterministic.
  always_comb begin
    w_sum   = {1'b0, acc_q} + {1'b0, frac_q};
    w_carry = w_sum[FRAC_W] & ~clr;
    w_raw   = {1'b0, int_q} + {{INT_W{1'b0}}, w_carry};
    w_sat   = (w_raw > c_t_max);
    w_code  = w_sat ? INT_W'(T) : w_raw[INT_W-1:0];
  end

  dco_bin2therm #(
    .INT_W (INT_W)
  ) u_bin2therm (
    .code_i  (w_code),
    .therm_o (w_therm)
  );

  // Stage 2 next state: everything holds while disabled, sat is a pulse.
  always_comb begin
    acc_d   = acc_q;
    code_d  = code_q;
    therm_d = therm_q;
    sat_d   = 1'b0;
    if (en) begin
      acc_d   = clr ? '0 : w_sum[FRAC_W-1:0];
      code_d  = w_code;
      therm_d = w_therm;
      sat_d   = w_sat;
    end
  end

  // State registers; reset clears the outputs without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_q   <= '0;
      frac_q  <= '0;
      acc_q   <= '0;
      code_q  <= '0;
      therm_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      int_q   <= int_d;
      frac_q  <= frac_d;
      acc_q   <= acc_d;
      code_q  <= code_d;
      therm_q <= therm_d;
      sat_q   <= sat_d;
    end
  end

  assign therm_o = therm_q;
  assign code_o  = code_q;
  assign sat_o   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dco_tw_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dco_tw_decoder
//  Description : Self-checking bench for dco_tw_decoder (INT_W=6, FRAC_W=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dco_tw_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, clr, tune_valid;
  logic [9:0]  tune_i;
  logic [62:0] therm_o;
  logic [5:0]  code_o;
  logic        sat_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, in plain integers.
  int m_int, m_frac, m_acc, m_code;
  logic m_sat;

  dco_tw_decoder #(.INT_W(6), .FRAC_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .tune_valid (tune_valid),
    .tune_i     (tune_i),
    .therm_o    (therm_o),
    .code_o     (code_o),
    .sat_o      (sat_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] therm_of(input int code);
    return (64'd1 << code) - 64'd1;
  endfunction

  task automatic model_reset();
    m_int = 0; m_frac = 0; m_acc = 0; m_code = 0; m_sat = 1'b0;
  endtask

  // Behavioural step: fractional average via integer division and modulo.
  task automatic model_step(input logic e, input logic c, input logic v, input logic [9:0] t);
    int sum, carry, raw;
    if (e) begin
      sum   = m_acc + m_frac;
      carry = c ? 0 : sum / 16;
      m_acc = c ? 0 : sum % 16;
      raw   = m_int + carry;
      m_sat = (raw > 63);
      m_code = (raw > 63) ? 63 : raw;
      if (v) begin
        m_int  = int'(t) / 16;
        m_frac = int'(t) % 16;
      end
    end else begin
      m_sat = 1'b0;
    end
  endtask

  // One clock with model comparison after the edge.
  task automatic cycle(input logic e, input logic c, input logic v, input logic [9:0] t);
    en = e; clr = c; tune_valid = v; tune_i = t;
    @(posedge clk);
    model_step(e, c, v, t);
    #1;
    check("code", 64'(code_o), 64'(m_code));
    check("therm", 64'(therm_o), therm_of(m_code));
    check("sat", 64'(sat_o), 64'(m_sat));
    check("popcount", 64'($countones(therm_o)), 64'(code_o));
  endtask

  typedef struct {
    logic       e, c, v;
    logic [9:0] t;
    int         code;
    logic       sat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int cnt, k;
    logic found;
    logic [5:0] frozen_code;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'h0A0, 0,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 10'h0A8, 10, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'h000, 11, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'h000, 11, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 10'h3FF, 10, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 10'h000, 63, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 10'h000, 63, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10'h010, 63, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 10'h000, 63, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 10'h000, 63, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 10'h000, 63, 1'b1};

    rst = 1'b1; en = 1'b0; clr = 1'b0; tune_valid = 1'b0; tune_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_code", 64'(code_o), 64'd0);
    check("reset_therm", 64'(therm_o), 64'd0);
    check("reset_sat", 64'(sat_o), 64'd0);
    rst = 1'b0;

    // Table-driven sequence from the reset state.
    foreach (vecs[i]) begin
      en = vecs[i].e; clr = vecs[i].c; tune_valid = vecs[i].v; tune_i = vecs[i].t;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_code", i), 64'(code_o), 64'(vecs[i].code));
      check($sformatf("vec%0d_therm", i), 64'(therm_o), therm_of(vecs[i].code));
      check($sformatf("vec%0d_sat", i), 64'(sat_o), 64'(vecs[i].sat));
    end

    // Asynchronous reset between edges clears outputs immediately.
    en = 1'b1; tune_valid = 1'b0; clr = 1'b0;
    rst = 1'b1;
    #2;
    check("async_rst_code", 64'(code_o), 64'd0);
    check("async_rst_therm", 64'(therm_o), 64'd0);
    check("async_rst_sat", 64'(sat_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 10'h000);

    // Integer-only word holds steadily, never saturating.
    cycle(1'b1, 1'b0, 1'b1, 10'h0A0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 10'h000);
      if (code_o != 6'd10 || sat_o) cnt++;
    end
    check("hold_0a0_bad_cycles", 64'(cnt), 64'd0);

    // Half-LSB fraction: 8 of every 16 cycles at 11.
    cycle(1'b1, 1'b0, 1'b1, 10'h0A8);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 10'h000);
      if (code_o == 6'd11) cnt++;
    end
    check("frac8_count11", 64'(cnt), 64'd8);

    // 1/16 fraction, then clr restarts the accumulator.
    cycle(1'b1, 1'b0, 1'b1, 10'h0A1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 10'h000);
      if (code_o == 6'd11) cnt++;
    end
    check("frac1_count11", 64'(cnt), 64'd1);
    cycle(1'b1, 1'b1, 1'b0, 10'h000);
    k = 0; found = 1'b0;
    while (!found && k < 24) begin
      cycle(1'b1, 1'b0, 1'b0, 10'h000);
      k++;
      if (code_o == 6'd11) found = 1'b1;
    end
    check("clr_delay", 64'(k), 64'd16);

    // Full-scale word: clipped to 63, saturation 15 of 16 cycles.
    cycle(1'b1, 1'b0, 1'b1, 10'h3FF);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 10'h000);
      if (sat_o) cnt++;
    end
    check("sat_count", 64'(cnt), 64'd15);

    // Freeze for 5 cycles with a competing tune_valid, then resume.
    cycle(1'b1, 1'b0, 1'b1, 10'h0A5);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 10'h000);
    frozen_code = code_o;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 10'h3F0);
      check("freeze_code", 64'(code_o), 64'(frozen_code));
    end
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 10'h000);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0), 10'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
